vga_1bit_scan: RTL and testbench



---
 rtl/vga_1bit_scan.sv | 213 +++++++++++++++++++++
 tb/tb_vga_1bit_scan.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_1bit_scan.sv
// vga_1bit_scan: VGA timing plus MSB-first 1-bit serialiser fed from a 16-bit FIFO.
// Optional feature macro VGA_UNDERFLOW_CNT_EN builds the 16-bit underflow counter.
module vga_1bit_scan #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        fifo_read_read,
  input  logic [15:0] fifo_read_readdata,
  input  logic        fifo_rdempty,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_pixel,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr,
  output logic [15:0] underflow_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_READ,
    PF_CAPTURE
  } pf_e;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [15:0]   word_buf_q, word_buf_d;
  logic          buf_valid_q, buf_valid_d;
  pf_e           pf_q, pf_d;
  logic          rd_q, rd_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          pix_q, pix_d;
  logic          fs_q, fs_d;
  logic          uf_q, uf_d;
  logic          pix_en;
  logic          word_ld;
  logic          uf_evt;

  always_comb begin
    pix_en      = enable && (div_cnt_q == DIV_LAST);
    div_cnt_d   = div_cnt_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    shreg_d     = shreg_q;
    word_buf_d  = word_buf_q;
    buf_valid_d = buf_valid_q;
    pf_d        = pf_q;
    rd_d        = 1'b0;
    hs_d        = hs_q;
    vs_d        = vs_q;
    pix_d       = pix_q;
    fs_d        = 1'b0;
    word_ld     = 1'b0;

    if (!enable) begin
      div_cnt_d = '0;
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      hs_d      = 1'b1;
      vs_d      = 1'b1;
      pix_d     = 1'b0;
    end else begin
      div_cnt_d = pix_en ? '0 : div_cnt_q + DW'(1);
      if (pix_en) begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
        hs_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        if ((h_cnt_q < H_ACT) && (v_cnt_q < V_ACT)) begin
          if (h_cnt_q[3:0] == 4'd0) begin
            // An empty buffer serialises as an all-zero word.
            word_ld     = 1'b1;
            pix_d       = buf_valid_q & word_buf_q[15];
            shreg_d     = buf_valid_q ? {word_buf_q[14:0], 1'b0} : '0;
            buf_valid_d = 1'b0;
          end else begin
            pix_d   = shreg_q[15];
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end else begin
          pix_d = 1'b0;
        end
      end
    end

    // Capture comes after the load so a same-cycle fill leaves the buffer valid.
    unique case (pf_q)
      PF_IDLE: begin
        if (enable && !buf_valid_q && !fifo_rdempty) begin
          rd_d = 1'b1;
          pf_d = PF_READ;
        end
      end
      PF_READ: pf_d = PF_CAPTURE;
      PF_CAPTURE: begin
        word_buf_d  = fifo_read_readdata;
        buf_valid_d = 1'b1;
        pf_d        = PF_IDLE;
      end
      default: pf_d = PF_IDLE;
    endcase

    uf_evt = word_ld && !buf_valid_q;
    if (uf_evt) begin
      uf_d = 1'b1;
    end else if (underflow_clr) begin
      uf_d = 1'b0;
    end else begin
      uf_d = uf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      shreg_q     <= '0;
      word_buf_q  <= '0;
      buf_valid_q <= 1'b0;
      pf_q        <= PF_IDLE;
      rd_q        <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      pix_q       <= 1'b0;
      fs_q        <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      shreg_q     <= shreg_d;
      word_buf_q  <= word_buf_d;
      buf_valid_q <= buf_valid_d;
      pf_q        <= pf_d;
      rd_q        <= rd_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      pix_q       <= pix_d;
      fs_q        <= fs_d;
      uf_q        <= uf_d;
    end
  end

`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (uf_evt) begin
      if (ucnt_q != 16'hFFFF) begin
        ucnt_d = ucnt_q + 16'd1;
      end
    end else if (underflow_clr) begin
      ucnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underflow_cnt = ucnt_q;
`else
  assign underflow_cnt = 16'h0;
`endif

  assign fifo_read_read = rd_q;
  assign vga_hs         = hs_q;
  assign vga_vs         = vs_q;
  assign vga_pixel      = pix_q;
  assign frame_start    = fs_q;
  assign underflow      = uf_q;

endmodule

// File: tb/tb_vga_1bit_scan.sv
// tb_vga_1bit_scan: two scanners (pixel divide 1 and 2) on small timing,
// random FIFO/enable/clear traffic checked every cycle against a frame-arithmetic model.
module tb_vga_1bit_scan;

  localparam int HA = 32, HF = 2, HS = 4, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DEPTH = 1024;
`ifdef VGA_UNDERFLOW_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, enable, clr;
  logic [1:0] rd, empty, hs, vs, pix, fs, uf;
  logic [15:0] rdata0, rdata1, ucnt0, ucnt1;

  logic [15:0] mem [DEPTH];
  int wr_ptr = 0;
  int rp0 = 0;
  int rp1 = 0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_1bit_scan #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_div1 (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_read_read(rd[0]), .fifo_read_readdata(rdata0),
    .fifo_rdempty(empty[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_pixel(pix[0]),
    .frame_start(fs[0]), .underflow(uf[0]),
    .underflow_clr(clr), .underflow_cnt(ucnt0)
  );

  vga_1bit_scan #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_div2 (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_read_read(rd[1]), .fifo_read_readdata(rdata1),
    .fifo_rdempty(empty[1]),
    .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_pixel(pix[1]),
    .frame_start(fs[1]), .underflow(uf[1]),
    .underflow_clr(clr), .underflow_cnt(ucnt1)
  );

  // Normal-mode FIFOs sharing one word stream: data valid the clk after a read.
  assign empty[0] = (rp0 == wr_ptr);
  assign empty[1] = (rp1 == wr_ptr);

  always @(posedge clk) begin
    if (rd[0]) begin
      rdata0 <= mem[rp0 % DEPTH];
      rp0 <= rp0 + 1;
    end
    if (rd[1]) begin
      rdata1 <= mem[rp1 % DEPTH];
      rp1 <= rp1 + 1;
    end
  end

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % DEPTH] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Reference model: pixel n = tick/div, position from n, word per 16 pixels.
  int tick [2];
  int mp [2];
  int mrd [2];
  int mwidx [2];
  int e_cnt [2];
  bit mv [2];
  bit e_hs [2], e_vs [2], e_pix [2], e_fs [2], e_rd [2], e_uf [2];
  logic [15:0] mw [2];
  logic [15:0] mcur [2];
  int edges = 0;

  task automatic model_step(input int i);
    int d, n, h, v, p0;
    bit ld, ov;
    logic [15:0] ow;
    d = i + 1;
    if (reset) begin
      tick[i] = 0; mv[i] = 0; mw[i] = '0; mp[i] = 0; mcur[i] = '0;
      e_hs[i] = 1; e_vs[i] = 1; e_pix[i] = 0; e_fs[i] = 0;
      e_rd[i] = 0; e_uf[i] = 0; e_cnt[i] = 0;
      return;
    end
    ov = mv[i]; ow = mw[i]; p0 = mp[i]; ld = 0;
    e_fs[i] = 0;
    e_rd[i] = 0;
    if (!enable) begin
      tick[i] = 0;
      e_hs[i] = 1; e_vs[i] = 1; e_pix[i] = 0;
    end else begin
      if (tick[i] % d == d - 1) begin
        n = tick[i] / d;
        h = n % HT;
        v = (n / HT) % VT;
        e_hs[i] = !(h >= HA + HF && h < HA + HF + HS);
        e_vs[i] = !(v >= VA + VF && v < VA + VF + VS);
        e_fs[i] = (h == 0 && v == 0);
        if (h < HA && v < VA) begin
          if (h % 16 == 0) begin
            ld = 1;
            mcur[i] = ov ? ow : 16'h0;
          end
          e_pix[i] = mcur[i][15 - (h % 16)];
        end else begin
          e_pix[i] = 0;
        end
      end
      tick[i] = tick[i] + 1;
    end
    if (ld && !ov) begin
      e_uf[i] = 1;
      if (CNT_EN && e_cnt[i] < 65535) e_cnt[i] = e_cnt[i] + 1;
    end else if (clr) begin
      e_uf[i] = 0;
      e_cnt[i] = 0;
    end
    if (ld) mv[i] = 0;
    if (p0 == 1) begin
      mw[i] = mem[mwidx[i] % DEPTH];
      mv[i] = 1;
      mp[i] = 0;
    end else if (p0 == 2) begin
      mp[i] = 1;
    end else if (enable && !ov && mrd[i] != wr_ptr) begin
      e_rd[i] = 1;
      mp[i] = 2;
      mwidx[i] = mrd[i];
      mrd[i] = mrd[i] + 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    edges = edges + 1;
  end

  always @(negedge clk) begin
    logic [5:0] got, exp;
    logic [15:0] gc;
    if (edges > 0) begin
      for (int i = 0; i < 2; i++) begin
        gc = (i == 0) ? ucnt0 : ucnt1;
        got = {hs[i], vs[i], pix[i], fs[i], rd[i], uf[i]};
        exp = {e_hs[i], e_vs[i], e_pix[i], e_fs[i], e_rd[i], e_uf[i]};
        n_checks = n_checks + 1;
        if (got !== exp || gc !== 16'(e_cnt[i])) begin
          n_fail = n_fail + 1;
          if (n_fail <= 30)
            $display("FAIL model_cmp dut%0d t=%0t hs,vs,pix,fs,rd,uf got %b cnt %h want %b cnt %h",
                     i, $time, got, gc, exp, 16'(e_cnt[i]));
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic wait_fs(input int i, input int lim, output bit ok);
    ok = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (fs[i]) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    logic [39:0] hsl;
    logic [31:0] pl;
    bit fs_first, ok, idle_bad, rd_seen;
    int p, vs_lo, vs_first, low_left;

    reset = 1; enable = 1; clr = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_div1", {ucnt0, hs[0], vs[0], pix[0], fs[0], rd[0], uf[0]},
        {16'h0, 6'b110000});
    chk("reset_outputs_div2", {ucnt1, hs[1], vs[1], pix[1], fs[1], rd[1], uf[1]},
        {16'h0, 6'b110000});

    // Empty FIFO: timing pins and underflow on the first active word.
    reset = 0;
    vs_lo = 0; vs_first = -1; fs_first = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hsl[k] = hs[0];
      if (k == 0) fs_first = fs[0];
    end
    chk("hs_line_pattern", hsl, 40'hC3_FFFF_FFFF);
    chk("fs_first_pixel", fs_first, 1);
    chk("uf_first_word", uf[0], 1);
    p = 39; ok = 0;
    while (p < 600) begin
      @(negedge clk);
      p = p + 1;
      if (fs[0]) begin
        ok = 1;
        break;
      end
      if (!vs[0]) begin
        if (vs_first < 0) vs_first = p;
        vs_lo = vs_lo + 1;
      end
    end
    chk("fs_period_div1", ok ? p : -1, 280);
    chk("vs_first_low", vs_first, 200);
    chk("vs_low_clks", vs_lo, 40);
    wait_fs(1, 1200, ok);
    chk("fs_seen_div2", ok, 1);
    p = 0; ok = 0;
    while (p < 1200) begin
      @(negedge clk);
      p = p + 1;
      if (fs[1]) begin
        ok = 1;
        break;
      end
    end
    chk("fs_period_div2", ok ? p : -1, 560);

    // Prefilled FIFO: first word underflows, later words land MSB-first.
    @(negedge clk);
    reset = 1;
    push(16'hA5F0);
    push(16'h0001);
    for (int k = 0; k < 6; k++) push(16'($urandom));
    repeat (2) @(negedge clk);
    reset = 0;
    pl = '0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      pl = {pl[30:0], pix[0]};
    end
    chk("line0_pixels", pl, 32'h0000_A5F0);
    repeat (8) @(negedge clk);
    pl = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      pl = {pl[30:0], pix[0]};
    end
    chk("line1_word0", pl, 32'h0000_0001);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("uf_cleared", {ucnt0, 15'h0, uf[0]}, 32'h0);
    wait_fs(0, 400, ok);
    chk("fs_frame1", ok, 1);
    repeat (16) @(negedge clk);
    chk("uf_second_word", uf[0], 1);
    chk("ucnt_second_word", ucnt0, CNT_EN ? 16'd1 : 16'd0);

    // Enable dropped mid-line for 10 clks.
    repeat (15) @(negedge clk);
    enable = 0;
    idle_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (hs !== 2'b11 || vs !== 2'b11 || pix !== 2'b00 ||
          rd !== 2'b00 || fs !== 2'b00)
        idle_bad = 1;
    end
    chk("idle_while_disabled", idle_bad, 0);
    enable = 1;
    @(negedge clk);
    chk("fs_reenable_div1", fs[0], 1);
    chk("fs_reenable_div2_early", fs[1], 0);
    @(negedge clk);
    chk("fs_reenable_div2", fs[1], 1);

    // Random traffic: pushes, clears, enable gaps.
    low_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) push(16'($urandom));
      clr = ($urandom_range(0, 59) == 0);
      if (low_left > 0) begin
        low_left = low_left - 1;
        if (low_left == 0) enable = 1;
      end else if ($urandom_range(0, 299) == 0) begin
        enable = 0;
        low_left = $urandom_range(1, 20);
      end
    end
    @(negedge clk);
    enable = 1; clr = 0;

    // Reset while a read is in its capture cycle.
    for (int k = 0; k < 4; k++) push(16'($urandom));
    rd_seen = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (rd[0]) begin
        rd_seen = 1;
        break;
      end
    end
    chk("read_seen", rd_seen, 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("reset_in_capture", {ucnt0, hs[0], vs[0], pix[0], fs[0], rd[0], uf[0]},
        {16'h0, 6'b110000});
    reset = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) push(16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
